// File: rtl/card_draw_unit_if.sv
// Draw request / result bundle between GameControl and the card draw unit.
// The master issues requests; the slave scans and returns the selected card.
interface card_draw_unit_if;
  logic         draw_req;
  logic [105:0] available_card;
  logic         busy;
  logic         draw_done;
  logic         draw_empty;
  logic [6:0]   draw_idx;
  logic [5:0]   draw_card;

  modport master (
    output draw_req,
    output available_card,
    input  busy,
    input  draw_done,
    input  draw_empty,
    input  draw_idx,
    input  draw_card
  );

  modport slave (
    input  draw_req,
    input  available_card,
    output busy,
    output draw_done,
    output draw_empty,
    output draw_idx,
    output draw_card
  );
endinterface

// File: rtl/card_draw_unit.sv
// Random card draw: snapshot the deck, start at an LFSR-derived position,
// scan one slot per cycle with wrap-around, report card or empty deck.
module card_draw_unit #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  card_draw_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [15:0]  r_lfsr;
  logic [105:0] r_snap;
  logic [6:0]   r_ptr;
  logic [6:0]   r_cnt;
  logic [6:0]   r_idx;
  logic [5:0]   r_card;
  logic         r_empty;

  logic [6:0]   w_l;
  logic [6:0]   w_start;
  logic [6:0]   w_ptr_inc;
  logic [5:0]   w_card;
  logic         w_accept;
  logic         w_av_zero;
  logic         w_hit;
  logic         w_last;
  logic         w_fb;

  assign w_fb      = r_lfsr[15] ^ r_lfsr[13]
                   ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_l       = r_lfsr[6:0];
  assign w_start   = (w_l < 7'd106) ? w_l
                                    : w_l - 7'd106;
  assign w_ptr_inc = (r_ptr == 7'd105) ? 7'd0
                                       : r_ptr + 7'd1;
  // Two instances per type: upper half folds onto 0..52
  assign w_card    = (r_ptr < 7'd53) ? r_ptr[5:0]
                                     : r_ptr[5:0] - 6'd53;
  assign w_av_zero = (bus.available_card == '0);
  assign w_accept  = (r_state == IDLE) && bus.draw_req;
  assign w_hit     = (r_state == SCAN) && r_snap[r_ptr];
  assign w_last    = (r_state == SCAN) && !r_snap[r_ptr]
                  && (r_cnt == 7'd105);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.draw_req)
          w_state_nxt = w_av_zero ? DONE : SCAN;
      end
      SCAN: begin
        if (w_hit || w_last)
          w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr  <= SEED;
      r_snap  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_card  <= '0;
      r_empty <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      if (w_accept) begin
        r_snap  <= bus.available_card;
        r_ptr   <= w_start;
        r_cnt   <= '0;
        r_empty <= w_av_zero;
      end else if (w_hit) begin
        r_idx   <= r_ptr;
        r_card  <= w_card;
        r_empty <= 1'b0;
      end else if (r_state == SCAN) begin
        r_ptr <= w_ptr_inc;
        r_cnt <= r_cnt + 7'd1;
        if (w_last) r_empty <= 1'b1;
      end
    end
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.draw_done  = (r_state == DONE);
  assign bus.draw_empty = (r_state == DONE) && r_empty;
  assign bus.draw_idx   = r_idx;
  assign bus.draw_card  = r_card;

endmodule

// File: doc/card_draw_unit.md
# card_draw_unit

Random card-draw engine in the GameControl path, directly upstream of the memory stage. On a draw request it snapshots the memory stage's `available_card` vector and picks one available card, starting from a pseudo-random position and scanning with wrap-around. It returns the card code and index, which GameControl forwards to the memory stage as `ctrl_card`. It also reports an empty deck when no card is available.

## Interface
- `SEED` — default `16'hACE1` — LFSR reset value; must be non-zero.
- `clk` — in — 1 — system clock; all state updates on the rising edge.
- `rst` — in — 1 — asynchronous, active-low reset.
- `draw_req` — in — 1 — single-cycle request pulse; sampled only in IDLE.
- `available_card` — in — 106 — bit i = 1 means card instance i is in the deck; driven by the memory stage.
- `busy` — out — 1 — high in SCAN and DONE.
- `draw_done` — out — 1 — one-cycle completion pulse.
- `draw_empty` — out — 1 — valid with `draw_done`; 1 means no card was available.
- `draw_idx` — out — 7 — selected instance index, 0..105.
- `draw_card` — out — 6 — selected card code, 0..52.

## Operation
- **Card code mapping:**
  - `draw_card = draw_idx` when `draw_idx < 53`.
  - `draw_card = draw_idx - 53` otherwise, since each of the 53 types has two instances.
- **LFSR:**
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts left every cycle; new bit 0 = b15^b13^b12^b10.
  - Free-running from reset and independent of state.
  - Reset value is `SEED`.
- **Start position:** l = lfsr[6:0] in the cycle `draw_req` is accepted.
  - start = l when l < 106.
  - start = l − 106 otherwise (covers 106..127 → 0..21).
- **IDLE:**
  - On `draw_req`: latch `available_card` into snap, set ptr = start, set cnt = 0.
  - If `available_card == 0`: go to DONE with the empty flag set.
  - Otherwise go to SCAN.
- **SCAN:** one position is examined per cycle.
  - If snap[ptr] = 1: latch `draw_idx` = ptr and the mapped `draw_card`, clear empty, go to DONE.
  - Otherwise advance ptr (105 wraps to 0) and increment cnt.
  - If cnt reaches 105 with no hit, go to DONE with empty set. This is a safety path and is unreachable given the IDLE check.
- **DONE:**
  - `draw_done` = 1 and `draw_empty` = empty flag for exactly this one cycle.
  - Return to IDLE.
- **Output hold:**
  - `draw_idx` and `draw_card` hold their last found value until the next hit.
  - On an empty result they are unchanged.
- **Snapshot:** the scan uses snap only, so changes to `available_card` during SCAN have no effect.
- **Requests while busy:** `draw_req` in SCAN or DONE is ignored, not queued.

## Timing
- **Reset values:**
  - State = IDLE.
  - `busy`, `draw_done`, `draw_empty` = 0.
  - `draw_idx`, `draw_card` = 0.
  - lfsr = `SEED`.
  - snap, ptr, cnt = 0.
- **Request sampled in cycle 0** (state IDLE):
  - Hit at offset k from start (k = 0..105, modulo 106): SCAN examines start+k in cycle k+1, and `draw_done` is high in cycle k+2. Latency is 2 to 107 cycles.
  - Empty deck: `draw_done` = 1 and `draw_empty` = 1 in cycle 1.
- **Earliest next request:** the cycle after `draw_done`.
- **`busy` timing:**
  - High from cycle 1 through the `draw_done` cycle inclusive.
  - Low in IDLE.
- **Mid-operation reset:**
  - `rst` low at any time forces all reset values immediately (asynchronously).
  - No `draw_done` is emitted for the aborted draw.
  - The LFSR restarts from `SEED`.
- **Output stability:** `draw_idx` and `draw_card` change only on the clock edge that enters DONE.

## Test plan
- **Single card:** `available_card` = only bit 70, request → `draw_done` with `draw_idx` = 70, `draw_card` = 17, `draw_empty` = 0, within 107 cycles of the request.
- **Empty deck:** all-zero `available_card`, request in cycle 0 → `draw_done` = 1 and `draw_empty` = 1 in cycle 1; `draw_idx` and `draw_card` unchanged from the prior value.
- **Full deck:** all-ones `available_card`; bench models the LFSR from reset and computes start → `draw_idx` = start, `draw_done` exactly 2 cycles after the request.
- **Wrap-around:** only bit 0 set, request when start = 100 (bench-computed) → `draw_idx` = 0, `draw_card` = 0, `draw_done` in cycle 8.
- **Snapshot and busy:**
  - Clear bit 70 in `available_card` during SCAN → result is still 70.
  - Second `draw_req` mid-scan → exactly one `draw_done`.
- **Mid-scan reset:** `rst` low in cycle 5 of a scan → `busy`, `draw_done`, `draw_idx` = 0 at once, state IDLE. A fresh request after release completes normally.
